uart_tx_fifo_fsm: RTL and testbench

//  Transmit-side counterpart of the UART receive path. Drains bytes from the TX FIFO
//  (1-cycle read latency), frames each as UART 8-N-1/8-N-2 (LSB first) and drives the

---
 rtl/uart_tx_fifo_fsm.sv | 151 +++++++++++++++
 tb/tb_uart_tx_fifo_fsm.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_fsm.sv
// UART transmitter: pops bytes from the TX FIFO (1-cycle read latency) and
// sends each as an 8-N-1 / 8-N-2 frame, LSB first, on the serial line.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_tx_en      allow new frames (sampled only between frames)
//   i_fifo_empty TX FIFO empty flag
//   i_fifo_data  TX FIFO read data, valid the cycle after o_rden_fifo
//   o_rden_fifo  one-cycle FIFO read strobe per byte
//   o_tx         serial output, idle high
//   o_busy       high from the read strobe through the last stop-bit cycle
//   o_tx_done    one-cycle pulse on the last stop-bit cycle
//   o_byte_cnt   bytes transmitted, modulo 1024
module uart_tx_fifo_fsm #(
   parameter int CLKS_PER_BIT = 868,
   parameter int STOP_BITS    = 1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_tx_en,
   input  logic       i_fifo_empty,
   input  logic [7:0] i_fifo_data,
   output logic       o_rden_fifo,
   output logic       o_tx,
   output logic       o_busy,
   output logic       o_tx_done,
   output logic [9:0] o_byte_cnt
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    STOP_MAX = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_LATCH,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t          state;
   state_t          state_n;
   logic [BW-1:0]   baud;
   logic [BW-1:0]   baud_n;
   logic [2:0]      bit_cnt;
   logic [2:0]      bit_n;
   logic [7:0]      shift;
   logic [7:0]      shift_n;
   logic            baud_end;
   logic            tx_n;
   logic            done_n;

   assign baud_end = (baud == BAUD_MAX);

   // Every output is a flop loaded from the next-state decode, so each
   // output lines up with the state it describes without any comb path.
   always_comb begin
      state_n = state;
      bit_n   = bit_cnt;
      shift_n = shift;
      case (state)
         S_IDLE: begin
            if (i_tx_en && !i_fifo_empty) state_n = S_RD;
         end
         S_RD: begin
            state_n = S_LATCH;
         end
         S_LATCH: begin
            shift_n = i_fifo_data;
            state_n = S_START;
         end
         S_START: begin
            if (baud_end) begin
               state_n = S_DATA;
               bit_n   = 3'd0;
            end
         end
         S_DATA: begin
            if (baud_end) begin
               if (bit_cnt == 3'd7) begin
                  state_n = S_STOP;
                  bit_n   = 3'd0;
               end else begin
                  shift_n = shift >> 1;
                  bit_n   = bit_cnt + 3'd1;
               end
            end
         end
         S_STOP: begin
            // bit_cnt doubles as the stop-bit index
            if (baud_end) begin
               if (bit_cnt == STOP_MAX) begin
                  state_n = S_IDLE;
                  bit_n   = 3'd0;
               end else begin
                  bit_n   = bit_cnt + 3'd1;
               end
            end
         end
         default: begin
            state_n = S_IDLE;
            bit_n   = 3'd0;
         end
      endcase

      if (state_n != state || baud_end ||
          state_n == S_IDLE || state_n == S_RD ||
          state_n == S_LATCH)
         baud_n = '0;
      else
         baud_n = baud + BW'(1);

      tx_n = 1'b1;
      unique case (1'b1)
         (state_n == S_START): tx_n = 1'b0;
         (state_n == S_DATA):  tx_n = shift_n[0];
         default:              tx_n = 1'b1;
      endcase

      done_n = (state_n == S_STOP) && (baud_n == BAUD_MAX) &&
               (bit_n == STOP_MAX);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= S_IDLE;
         baud        <= '0;
         bit_cnt     <= 3'd0;
         shift       <= 8'd0;
         o_tx        <= 1'b1;
         o_rden_fifo <= 1'b0;
         o_busy      <= 1'b0;
         o_tx_done   <= 1'b0;
         o_byte_cnt  <= 10'd0;
      end else begin
         state       <= state_n;
         baud        <= baud_n;
         bit_cnt     <= bit_n;
         shift       <= shift_n;
         o_tx        <= tx_n;
         o_rden_fifo <= (state_n == S_RD);
         o_busy      <= (state_n != S_IDLE);
         o_tx_done   <= done_n;
         if (done_n) o_byte_cnt <= o_byte_cnt + 10'd1;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo_fsm.sv
// Directed bench for uart_tx_fifo_fsm at CLKS_PER_BIT=4, with a second
// instance at STOP_BITS=2. Each DUT has a small behavioural FIFO.
module tb_uart_tx_fifo_fsm;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx_en = 1'b1;

   logic       empty1 = 1'b1;
   logic [7:0] data1 = 8'd0;
   logic       rden1, tx1, busy1, done1;
   logic [9:0] cnt1;

   logic       empty2 = 1'b1;
   logic [7:0] data2 = 8'd0;
   logic       rden2, tx2, busy2, done2;
   logic [9:0] cnt2;

   logic [7:0] q1[$];
   logic [7:0] q2[$];
   int total = 0;
   int bad = 0;
   int rd1 = 0;
   int rd2 = 0;
   int npush1 = 0;
   int rd_snap;

   uart_tx_fifo_fsm #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_tx_en(tx_en),
      .i_fifo_empty(empty1), .i_fifo_data(data1),
      .o_rden_fifo(rden1), .o_tx(tx1), .o_busy(busy1),
      .o_tx_done(done1), .o_byte_cnt(cnt1)
   );

   uart_tx_fifo_fsm #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
      .i_clk(clk), .i_rst(rst), .i_tx_en(tx_en),
      .i_fifo_empty(empty2), .i_fifo_data(data2),
      .o_rden_fifo(rden2), .o_tx(tx2), .o_busy(busy2),
      .o_tx_done(done2), .o_byte_cnt(cnt2)
   );

   always #5 clk = ~clk;

   // FIFO models: pop on the read strobe, data valid for the next cycle
   always @(negedge clk) begin
      if (rden1) begin
         rd1++;
         if (q1.size() > 0) data1 = q1.pop_front();
         empty1 = (q1.size() == 0);
      end
   end

   always @(negedge clk) begin
      if (rden2) begin
         rd2++;
         if (q2.size() > 0) data2 = q2.pop_front();
         empty2 = (q2.size() == 0);
      end
   end

   function automatic logic tx_of(input bit s);
      return s ? tx2 : tx1;
   endfunction

   function automatic logic busy_of(input bit s);
      return s ? busy2 : busy1;
   endfunction

   function automatic logic done_of(input bit s);
      return s ? done2 : done1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push1(input logic [7:0] b);
      q1.push_back(b);
      npush1++;
      empty1 = 1'b0;
   endtask

   task automatic push2(input logic [7:0] b);
      q2.push_back(b);
      empty2 = 1'b0;
   endtask

   task automatic wait_fall(input bit s, input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (tx_of(s) === 1'b0) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("fall_timeout", 32'(seen), 32'd1);
   endtask

   task automatic wait_done(input bit s, input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done_of(s) === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      chk("done_timeout", 32'(seen), 32'd1);
   endtask

   // Called on the first negedge with the start bit low.
   task automatic check_frame(input bit s, input logic [7:0] b,
                              input int nstop, input int drop_at);
      int   len;
      logic e;
      len = (9 + nstop) * 4;
      for (int c = 0; c < len; c++) begin
         if (c < 4)       e = 1'b0;
         else if (c < 36) e = b[(c - 4) / 4];
         else             e = 1'b1;
         chk("frame_tx", 32'(tx_of(s)), 32'(e));
         chk("frame_busy", 32'(busy_of(s)), 32'd1);
         chk("frame_done", 32'(done_of(s)), 32'(c == len - 1));
         if (c == drop_at) tx_en = 1'b0;
         @(negedge clk);
      end
      chk("frame_end_busy", 32'(busy_of(s)), 32'd0);
      chk("frame_end_tx", 32'(tx_of(s)), 32'd1);
   endtask

   initial begin
      // 1: reset held with a byte waiting
      push1(8'hA5);
      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(tx1), 32'd1);
      chk("rst_rden", 32'(rden1), 32'd0);
      chk("rst_busy", 32'(busy1), 32'd0);
      chk("rst_done", 32'(done1), 32'd0);
      chk("rst_cnt", 32'(cnt1), 32'd0);
      chk("rst_reads", 32'(rd1), 32'd0);

      // 2: single byte 0xA5, fixed latency
      rst = 1'b0;
      @(negedge clk);
      chk("lat_rden1", 32'(rden1), 32'd1);
      chk("lat_busy", 32'(busy1), 32'd1);
      chk("lat_tx_rd", 32'(tx1), 32'd1);
      @(negedge clk);
      chk("lat_rden0", 32'(rden1), 32'd0);
      chk("lat_tx_latch", 32'(tx1), 32'd1);
      @(negedge clk);
      check_frame(1'b0, 8'hA5, 1, -1);
      chk("a5_cnt", 32'(cnt1), 32'd1);
      chk("a5_reads", 32'(rd1), 32'd1);

      // 3: back-to-back 0x00, 0xFF with three idle-high cycles
      push1(8'h00);
      push1(8'hFF);
      wait_fall(1'b0, 10);
      check_frame(1'b0, 8'h00, 1, -1);
      for (int i = 0; i < 3; i++) begin
         chk("gap_high", 32'(tx1), 32'd1);
         @(negedge clk);
      end
      check_frame(1'b0, 8'hFF, 1, -1);
      chk("b2b_cnt", 32'(cnt1), 32'd3);
      chk("b2b_reads", 32'(rd1), 32'd3);

      // 4: drop enable during data bit 3 of 0x3C
      push1(8'h3C);
      push1(8'h11);
      wait_fall(1'b0, 10);
      check_frame(1'b0, 8'h3C, 1, 17);
      rd_snap = rd1;
      repeat (20) @(negedge clk);
      chk("hold_reads", 32'(rd1), 32'(rd_snap));
      chk("hold_tx", 32'(tx1), 32'd1);
      chk("hold_busy", 32'(busy1), 32'd0);
      tx_en = 1'b1;
      wait_fall(1'b0, 10);
      check_frame(1'b0, 8'h11, 1, -1);
      chk("en_cnt", 32'(cnt1), 32'd5);

      // 5: reset in the middle of a data bit
      push1(8'h96);
      push1(8'h5A);
      wait_fall(1'b0, 10);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mrst_tx", 32'(tx1), 32'd1);
      chk("mrst_cnt", 32'(cnt1), 32'd0);
      chk("mrst_busy", 32'(busy1), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      wait_fall(1'b0, 10);
      check_frame(1'b0, 8'h5A, 1, -1);
      chk("mrst_after_cnt", 32'(cnt1), 32'd1);
      chk("mrst_reads", 32'(rd1), 32'(npush1));

      // 5b: two stop bits
      push2(8'hC3);
      wait_fall(1'b1, 10);
      check_frame(1'b1, 8'hC3, 2, -1);
      chk("stop2_cnt", 32'(cnt2), 32'd1);
      chk("stop2_reads", 32'(rd2), 32'd1);

      // 6: counter wrap 1023 -> 0 -> 1
      for (int i = 0; i < 1022; i++) push1(8'(i));
      for (int i = 0; i < 1022; i++) wait_done(1'b0, 100);
      chk("wrap_1023", 32'(cnt1), 32'd1023);
      push1(8'h01);
      wait_done(1'b0, 100);
      chk("wrap_0", 32'(cnt1), 32'd0);
      push1(8'h02);
      wait_done(1'b0, 100);
      chk("wrap_1", 32'(cnt1), 32'd1);
      repeat (20) @(negedge clk);
      chk("empty_reads", 32'(rd1), 32'(npush1));
      chk("empty_busy", 32'(busy1), 32'd0);
      chk("empty_tx", 32'(tx1), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
